// File: rtl/inst_rom_loader.sv
// ============================================================================
// inst_rom_loader
// ----------------------------------------------------------------------------
// Instruction memory that can be loaded from a word stream. It also serves
// CPU instruction fetches. After reset the block is EMPTY and holds the CPU
// pipeline. A load_start pulse opens a LOAD phase, during which loader words
// are written to consecutive memory locations from word 0. The load ends when
// the word flagged by load_last is written, or when the memory overflows.
// The block then moves to RUN, where the pipeline is released and fetches
// return the stored words with one cycle of latency.
//
// Parameters
//   ADDR_W      log2 of the memory depth in 32-bit words
//
// Ports
//   clk         single clock, rising edge
//   rst         asynchronous active-high reset
//   ce          fetch enable from the CPU fetch stage
//   addr        byte fetch address (word index = addr[ADDR_W+1:2])
//   inst        registered fetched instruction, 0 (NOP) when not fetching
//   load_start  one-cycle pulse that starts (or restarts) an image load
//   load_valid  loader word valid
//   load_data   loader word
//   load_last   final word of the image, qualified by load_valid
//   load_ready  high in LOAD: a loader word is accepted this cycle
//   stall_req   high while no valid image is present (EMPTY or LOAD)
//   load_words  number of words written by the current or last load
//   load_err    sticky overflow flag for the current or last load
// ============================================================================
module inst_rom_loader #(
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ce,
    input  logic [31:0]       addr,
    output logic [31:0]       inst,
    input  logic              load_start,
    input  logic              load_valid,
    input  logic [31:0]       load_data,
    input  logic              load_last,
    output logic              load_ready,
    output logic              stall_req,
    output logic [ADDR_W:0]   load_words,
    output logic              load_err
);

    localparam int DEPTH = 1 << ADDR_W;

    localparam logic [1:0] ST_EMPTY = 2'd0;
    localparam logic [1:0] ST_LOAD  = 2'd1;
    localparam logic [1:0] ST_RUN   = 2'd2;

    localparam logic [ADDR_W-1:0] PTR_ONE   = {{(ADDR_W-1){1'b0}}, 1'b1};
    localparam logic [ADDR_W-1:0] PTR_MAX   = {ADDR_W{1'b1}};
    localparam logic [ADDR_W:0]   WORDS_ONE = {{ADDR_W{1'b0}}, 1'b1};

    logic [1:0]        state;
    logic [ADDR_W-1:0] wr_ptr;
    logic [31:0]       mem [0:DEPTH-1];
    logic              xfer;
    logic [ADDR_W-1:0] rd_idx;
    logic              unused_addr_bits;

    // A load_start in LOAD takes priority over a transfer on the same edge.
    // While rst is high the state is held at EMPTY, so no write can occur.
    assign xfer   = (state == ST_LOAD) && load_valid && !load_start;

    // Byte offset and bits above the memory size are ignored, so fetch
    // addresses alias modulo the memory size.
    assign rd_idx = addr[ADDR_W+1:2];
    assign unused_addr_bits = ^{addr[31:ADDR_W+2], addr[1:0]};

    assign load_ready = (state == ST_LOAD);
    assign stall_req  = (state != ST_RUN);

    // Load control: state, write pointer, word count and overflow flag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= ST_EMPTY;
            wr_ptr     <= '0;
            load_words <= '0;
            load_err   <= 1'b0;
        end else begin
            case (state)
                ST_EMPTY, ST_RUN: begin
                    if (load_start) begin
                        state      <= ST_LOAD;
                        wr_ptr     <= '0;
                        load_words <= '0;
                        load_err   <= 1'b0;
                    end
                end
                ST_LOAD: begin
                    if (load_start) begin
                        wr_ptr     <= '0;
                        load_words <= '0;
                        load_err   <= 1'b0;
                    end else if (load_valid) begin
                        wr_ptr     <= wr_ptr + PTR_ONE;
                        load_words <= load_words + WORDS_ONE;
                        if (load_last) begin
                            state <= ST_RUN;
                        end else if (wr_ptr == PTR_MAX) begin
                            // Image larger than memory: keep the word just
                            // written, flag it and release the CPU anyway.
                            load_err <= 1'b1;
                            state    <= ST_RUN;
                        end
                    end
                end
                default: begin
                    state <= ST_EMPTY;
                end
            endcase
        end
    end

    // Memory contents are deliberately not reset so that a reload only
    // replaces the words it actually transfers.
    always_ff @(posedge clk) begin
        if (xfer) begin
            mem[wr_ptr] <= load_data;
        end
    end

    // Fetch port: one-cycle read latency, NOP whenever not fetching in RUN.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            inst <= 32'h0000_0000;
        end else if ((state == ST_RUN) && ce) begin
            inst <= mem[rd_idx];
        end else begin
            inst <= 32'h0000_0000;
        end
    end

endmodule

// File: doc/inst_rom_loader.md
INST_ROM_LOADER -- requirements
Module: inst_rom_loader

Interface
REQ-001 SHALL have parameter ADDR_W, default 10, meaning the memory holds 2^ADDR_W 32-bit words.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on the rising edge.
REQ-003 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have port ce  input  1  fetch enable from the CPU fetch stage.
REQ-005 SHALL have port addr  input  32  byte fetch address.
REQ-006 SHALL have port inst  output  32  fetched instruction word.
REQ-007 SHALL have port load_start  input  1  one-cycle pulse that begins an image load.
REQ-008 SHALL have port load_valid  input  1  loader word valid.
REQ-009 SHALL have port load_data  input  32  loader word.
REQ-010 SHALL have port load_last  input  1  marks the final word of the image; qualified by load_valid.
REQ-011 SHALL have port load_ready  output  1  block accepts a loader word this cycle.
REQ-012 SHALL have port stall_req  output  1  holds the CPU pipeline while no valid image is present.
REQ-013 SHALL have port load_words  output  ADDR_W+1  count of words written in the current or last load.
REQ-014 SHALL have port load_err  output  1  sticky overflow flag.

Function
REQ-015 SHALL implement a three-state FSM: EMPTY, LOAD, RUN.
REQ-016 SHALL enter EMPTY on reset and remain there until load_start is asserted.
REQ-017 SHALL move from EMPTY or RUN to LOAD on load_start, and SHALL clear the write pointer, load_words and load_err on that edge.
REQ-018 SHALL drive load_ready=1 only in LOAD; a word transfers on an edge where load_valid and load_ready are both 1.
REQ-019 SHALL write load_data to mem[pointer] on each transfer, then increment the pointer and load_words by 1.
REQ-020 SHALL move LOAD to RUN on a transfer with load_last=1; that word is written.
REQ-021 SHALL, on a transfer into word 2^ADDR_W-1 with load_last=0, write the word, set load_err=1 and move to RUN.
REQ-022 SHALL, if load_start is asserted while in LOAD, restart the load: clear pointer and load_words, and ignore any transfer on that same edge.
REQ-023 SHALL drive stall_req=1 in EMPTY and LOAD, and 0 in RUN, decoded combinationally from the state.
REQ-024 SHALL, in RUN with ce=1, register mem[addr[ADDR_W+1:2]] into inst, giving one-cycle read latency.
REQ-025 SHALL ignore addr[1:0] and all address bits above ADDR_W+1, so fetch addresses alias modulo the memory size.
REQ-026 SHALL register inst=0x00000000 (NOP) on any edge where ce=0 or the state is not RUN.
REQ-027 SHALL NOT reset memory contents; a reload overwrites only the words it transfers.

Reset
REQ-028 SHALL, on asserting rst, immediately force: state=EMPTY, inst=0, load_ready=0, stall_req=1, load_words=0, load_err=0, pointer=0.
REQ-029 SHALL abandon a load that is interrupted by reset and SHALL NOT perform any write while rst=1.

Verification
REQ-030 Reset then load 4 words (0x34011100, 0x34020020, 0x3403FF00, 0x3404FFFF) with the last flagged -> load_words=4, stall_req falls the edge after the last transfer, and a fetch at addr 0x8 returns 0x3403FF00 one cycle later.
REQ-031 In RUN, ce=0 with addr=0x0 -> inst=0 on the next edge; addr=0x1000 with ADDR_W=10 -> returns mem[0] (aliasing).
REQ-032 Hold load_valid low for 3 cycles mid-load -> no writes and load_words unchanged; load_ready stays 1 throughout.
REQ-033 With ADDR_W=2, send 4 words with no load_last -> load_err=1, state RUN, load_words=4; a fifth word offered gets load_ready=0.
REQ-034 Assert load_start together with load_valid in LOAD -> the word is not written, load_words=0, and the load restarts at pointer 0.
REQ-035 Assert rst during LOAD after 2 words -> stall_req=1, load_ready=0 and inst=0 immediately, state EMPTY; already-written words retain their values after a new load that transfers only word 0.
